run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
Host-side run controller that sits directly upstream of the processor top level and drives its Reset and Start inputs. It accepts a host run request and issues a DUT reset pulse, then a Start pulse. It waits for the processor's Ack (done) flag, with a timeout, and returns the measured cycle count and status to the host over a four-phase req/done handshake.

Parameters:
CW, 16, width of cycle counter and Cycles output
TIMEOUT, 16'hFFFF, RUN-state cycle limit before forced abort; must be >= 1 and < 2**CW
START_LEN, 2, number of cycles DutStart is held high; must be >= 1
PW, 2, width of program-select field

Ports:
Clk  input  1  clock, posedge only
Reset  input  1  synchronous, active-high reset
Req  input  1  host run request, level; four-phase handshake with Done
ProgSel  input  PW  program index; sampled when a request is accepted
DutAck  input  1  processor done flag (Ack)
DutReset  output  1  reset to processor, active high
DutStart  output  1  start to processor, active high
DutProgSel  output  PW  latched program index, stable from accept until next accept
Busy  output  1  high from request accept until Done asserts
Done  output  1  run complete; held until Req falls
TimedOut  output  1  valid with Done; 1 = TIMEOUT reached without Ack
Cycles  output  CW  RUN cycles counted before Ack; valid with Done; held until next accept

Behaviour:
- All outputs are registered. Reset (synchronous): state=IDLE; DutReset=0, DutStart=0, DutProgSel=0, Busy=0, Done=0, TimedOut=0, Cycles=0, internal counters=0.
- States: IDLE, RST, STRT, RUN, FIN.
- IDLE: when Req=1, latch ProgSel into DutProgSel, clear Cycles and TimedOut, set Busy=1, and go to RST. When Req=0, stay in IDLE.
- RST: exactly 1 cycle with DutReset=1, then go to STRT.
- STRT: DutStart=1 for exactly START_LEN consecutive cycles, counted by an internal pulse counter. Go to RUN after the last cycle. The cycle counter is cleared on entry to RUN.
- RUN, DutStart=0, DutAck sampled every cycle:
  - DutAck=1: go to FIN, TimedOut=0, Cycles holds its current value. If Ack is seen in the first RUN cycle, Cycles=0.
  - DutAck=0 and count+1==TIMEOUT: go to FIN, TimedOut=1, Cycles=TIMEOUT.
  - Otherwise: increment count.
  - If Ack and the timeout condition occur in the same cycle, Ack wins (TimedOut=0).
- FIN: Done=1 and Busy=0 from the first FIN cycle. Stay in FIN while Req=1. When Req=0, go to IDLE with Done=0 on the next edge.
- Latency: Req rising edge in IDLE to DutReset=1 is 1 cycle. Ack edge to Done=1 is 1 cycle.
- DutAck is ignored outside RUN. The processor Ack is combinational from instruction bits and may be high while idle.
- ProgSel changes after accept have no effect until the next accept.
- Req dropped during RST, STRT or RUN: the run continues; the sequencer enters FIN and immediately returns to IDLE, so Done pulses for 1 cycle.
- Req held high through FIN back to IDLE is not possible; a new run requires Req to fall and then rise.
- Reset asserted mid-run: return to IDLE in the next cycle with all outputs cleared. DutReset is not asserted by this block during its own reset; the processor shares the system Reset.
- Cycle counter never wraps; the timeout bound guarantees this.

Decomposition:
- Shared package `definitions`: state enum `seq_state_t` {IDLE, RST, STRT, RUN, FIN}, and constant `SEQ_TIMEOUT_DEFAULT`.
- One natural sub-module, `run_counter`: a CW-bit counter with clear, enable, and a terminal-match flag against TIMEOUT. It is reused for the START_LEN pulse count via a parameter.
- The FSM lives in run_sequencer.

Test Plan:
1. Reset, then Req=1 with ProgSel=2. DutAck rises 10 RUN cycles after DutStart falls. Required: DutReset high for 1 cycle, DutStart high for 2 cycles, then Done=1 with Cycles=10, TimedOut=0, DutProgSel=2.
2. TIMEOUT=20, DutAck held 0. Required: Done=1 with TimedOut=1 and Cycles=20. Busy is 0 from the Done cycle onward.
3. DutAck=1 throughout IDLE, RST and STRT. Required: no early completion; Done rises in the cycle after RUN entry with Cycles=0.
4. Handshake: Req held high 5 cycles after Done. Required: Done stays 1. After Req falls, Done=0 on the next edge and state is IDLE. Changing ProgSel during RUN leaves DutProgSel unchanged.
5. Reset asserted in RUN at Cycles=7. Required: next cycle all outputs 0 and state IDLE. A fresh Req starts a new RST pulse.
6. With TIMEOUT=20, DutAck rises in the same cycle count+1 reaches TIMEOUT. Required: TimedOut=0 and Cycles=19.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer.
//   seq_state_t         : sequencer FSM state encoding
//   SEQ_TIMEOUT_DEFAULT : default RUN-state cycle limit
package definitions;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    STRT,
    RUN,
    FIN
  } seq_state_t;

  localparam logic [15:0] SEQ_TIMEOUT_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/run_sequencer_counter.sv
// Up-counter with synchronous clear and enable, plus a flag that is high when
// the next increment would reach Terminal (Count + 1 == Terminal).
//   Clk, Reset : clock and synchronous active-high reset
//   Clear      : zero the count (wins over Enable)
//   Enable     : increment the count
//   Count      : current count, registered
//   Match      : Count + 1 == Terminal
module run_counter #(
  parameter int unsigned   CW       = 16,
  parameter logic [CW-1:0] Terminal = '1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Enable,
  output logic [CW-1:0] Count,
  output logic          Match
);

  logic [CW:0] countPlusOne;

  // One extra bit so the compare is exact even at the all-ones count.
  assign countPlusOne = {1'b0, Count} + {{CW{1'b0}}, 1'b1};
  assign Match        = (countPlusOne == {1'b0, Terminal});

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= '0;
    end else if (Enable) begin
      Count <= countPlusOne[CW-1:0];
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Host-side run controller: on a host request it pulses the processor reset,
// then holds start for START_LEN cycles, then counts RUN cycles until the
// processor Ack or TIMEOUT, and reports over a four-phase Req/Done handshake.
//   Clk, Reset       : clock, synchronous active-high reset
//   Req, ProgSel     : host request level and program index
//   DutAck           : processor done flag, only observed in RUN
//   DutReset/Start   : registered processor controls
//   DutProgSel       : program index latched at accept
//   Busy, Done       : handshake status
//   TimedOut, Cycles : run result, valid with Done, held until next accept
module run_sequencer
  import definitions::*;
#(
  parameter int unsigned   CW        = 16,
  parameter logic [CW-1:0] TIMEOUT   = CW'(SEQ_TIMEOUT_DEFAULT),
  parameter int unsigned   START_LEN = 2,
  parameter int unsigned   PW        = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req,
  input  logic [PW-1:0] ProgSel,
  input  logic          DutAck,
  output logic          DutReset,
  output logic          DutStart,
  output logic [PW-1:0] DutProgSel,
  output logic          Busy,
  output logic          Done,
  output logic          TimedOut,
  output logic [CW-1:0] Cycles
);

  seq_state_t stateQ, stateD;

  logic          cycClear, cycEnable, cycMatch;
  logic          pulseClear, pulseEnable, pulseMatch;
  logic [CW-1:0] pulseCount;
  logic          unusedPulse;
  logic          timedOutD;
  logic [PW-1:0] progSelD;

  // Cycles is the counter itself: cleared at accept, frozen outside RUN.
  run_counter #(
    .CW       (CW),
    .Terminal (TIMEOUT)
  ) u_cycle_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (cycClear),
    .Enable (cycEnable),
    .Count  (Cycles),
    .Match  (cycMatch)
  );

  run_counter #(
    .CW       (CW),
    .Terminal (CW'(START_LEN))
  ) u_pulse_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (pulseClear),
    .Enable (pulseEnable),
    .Count  (pulseCount),
    .Match  (pulseMatch)
  );

  // Only the terminal flag of the pulse counter is needed.
  assign unusedPulse = ^pulseCount;

  always_comb begin
    stateD      = stateQ;
    cycClear    = 1'b0;
    cycEnable   = 1'b0;
    pulseClear  = 1'b0;
    pulseEnable = 1'b0;
    timedOutD   = TimedOut;
    progSelD    = DutProgSel;
    unique case (stateQ)
      IDLE: begin
        if (Req) begin
          progSelD  = ProgSel;
          cycClear  = 1'b1;
          timedOutD = 1'b0;
          stateD    = RST;
        end
      end
      RST: begin
        pulseClear = 1'b1;
        stateD     = STRT;
      end
      STRT: begin
        if (pulseMatch) begin
          cycClear = 1'b1;
          stateD   = RUN;
        end else begin
          pulseEnable = 1'b1;
        end
      end
      RUN: begin
        // Ack has priority over the timeout on the same cycle.
        if (DutAck) begin
          timedOutD = 1'b0;
          stateD    = FIN;
        end else begin
          // Increment on the timeout cycle too, so Cycles lands on TIMEOUT.
          cycEnable = 1'b1;
          if (cycMatch) begin
            timedOutD = 1'b1;
            stateD    = FIN;
          end
        end
      end
      FIN: begin
        if (!Req) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ     <= IDLE;
      DutReset   <= 1'b0;
      DutStart   <= 1'b0;
      DutProgSel <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      TimedOut   <= 1'b0;
    end else begin
      stateQ     <= stateD;
      DutReset   <= (stateD == RST);
      DutStart   <= (stateD == STRT);
      DutProgSel <= progSelD;
      Busy       <= (stateD == RST) || (stateD == STRT) || (stateD == RUN);
      Done       <= (stateD == FIN);
      TimedOut   <= timedOutD;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  localparam int unsigned CW        = 16;
  localparam int unsigned PW        = 2;
  localparam int unsigned START_LEN = 2;
  localparam logic [CW-1:0] TIMEOUT = 16'd20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Req;
  logic [PW-1:0] ProgSel;
  logic          DutAck;
  logic          DutReset;
  logic          DutStart;
  logic [PW-1:0] DutProgSel;
  logic          Busy;
  logic          Done;
  logic          TimedOut;
  logic [CW-1:0] Cycles;

  typedef struct {
    logic          to;
    logic [CW-1:0] cyc;
    logic [PW-1:0] sel;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  run_sequencer #(
    .CW        (CW),
    .TIMEOUT   (TIMEOUT),
    .START_LEN (START_LEN),
    .PW        (PW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .ProgSel    (ProgSel),
    .DutAck     (DutAck),
    .DutReset   (DutReset),
    .DutStart   (DutStart),
    .DutProgSel (DutProgSel),
    .Busy       (Busy),
    .Done       (Done),
    .TimedOut   (TimedOut),
    .Cycles     (Cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: measures pulse widths and scores each completed run on Done rise.
  int   rstLen = 0;
  int   strtLen = 0;
  logic prevDone = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      rstLen  = 0;
      strtLen = 0;
    end else begin
      if (DutReset) rstLen++;
      if (DutStart) strtLen++;
      if (Done && !prevDone) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_done: got Done with empty queue, expected none");
        end else begin
          e = expQ.pop_front();
          check("sb_timedout", 32'(TimedOut), 32'(e.to));
          check("sb_cycles", 32'(Cycles), 32'(e.cyc));
          check("sb_progsel", 32'(DutProgSel), 32'(e.sel));
          check("sb_busy_at_done", 32'(Busy), 32'd0);
          check("sb_rst_len", rstLen, 32'd1);
          check("sb_start_len", strtLen, START_LEN);
        end
        rstLen  = 0;
        strtLen = 0;
      end
    end
    prevDone = Done;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_dutreset"}, 32'(DutReset), 32'd0);
    check({tag, "_dutstart"}, 32'(DutStart), 32'd0);
    check({tag, "_progsel"}, 32'(DutProgSel), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_timedout"}, 32'(TimedOut), 32'd0);
    check({tag, "_cycles"}, 32'(Cycles), 32'd0);
  endtask

  // Returns in the first RUN cycle (just after DutStart falls).
  task automatic wait_start_fall();
    int n;
    n = 0;
    while (!DutStart && n < 10) begin tick(); n++; end
    if (!DutStart) begin
      checks++; errors++;
      $display("FAIL wait_start_rise: got timeout, expected DutStart high");
    end
    n = 0;
    while (DutStart && n < 10) begin tick(); n++; end
    if (DutStart) begin
      checks++; errors++;
      $display("FAIL wait_start_fall: got timeout, expected DutStart low");
    end
  endtask

  // ackAfter < 0 means Ack never rises during RUN.
  task automatic run_once(input logic [PW-1:0] sel, input int ackAfter, input logic expTo,
                          input int expCyc, input int hold);
    exp_t e;
    int   n;
    e.to = expTo; e.cyc = CW'(expCyc); e.sel = sel;
    expQ.push_back(e);
    ProgSel = sel;
    Req     = 1'b1;
    tick();
    check("accept_dutreset", 32'(DutReset), 32'd1);
    check("accept_busy", 32'(Busy), 32'd1);
    wait_start_fall();
    check("no_early_done", 32'(Done), 32'd0);
    ProgSel = ~sel;  // must not disturb the latched index
    if (ackAfter >= 0) begin
      repeat (ackAfter) tick();
      DutAck = 1'b1;
    end
    n = 0;
    while (!Done && n < 100) begin tick(); n++; end
    if (!Done) begin
      checks++; errors++;
      $display("FAIL wait_done: got timeout, expected Done high");
    end
    DutAck = 1'b0;
    repeat (hold) begin
      tick();
      check("done_held", 32'(Done), 32'd1);
    end
    Req = 1'b0;
    tick();
    check("done_drop", 32'(Done), 32'd0);
    check("idle_busy", 32'(Busy), 32'd0);
  endtask

  initial begin
    int n;
    Reset = 1'b1; Req = 1'b0; ProgSel = '0; DutAck = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    Reset = 1'b0;
    tick();

    run_once(2'd2, 10, 1'b0, 10, 0);   // basic run
    run_once(2'd0, -1, 1'b1, 20, 0);   // timeout
    DutAck = 1'b1;                     // Ack high from idle onward
    run_once(2'd3, 0, 1'b0, 0, 0);
    run_once(2'd2, 5, 1'b0, 5, 5);     // Req held after Done
    run_once(2'd1, 19, 1'b0, 19, 0);   // Ack on the timeout cycle

    // Reset mid-run at Cycles == 7
    ProgSel = 2'd1;
    Req     = 1'b1;
    tick();
    wait_start_fall();
    n = 0;
    while (Cycles != 16'd7 && n < 30) begin tick(); n++; end
    check("midrun_cycles", 32'(Cycles), 32'd7);
    Reset = 1'b1;
    Req   = 1'b0;
    tick();
    Reset = 1'b0;
    check_all_zero("midrun_reset");
    run_once(2'd3, 4, 1'b0, 4, 0);

    n = 0;
    while (expQ.size() != 0 && n < 10) begin tick(); n++; end
    check("sb_queue_empty", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
